// File: rtl/bike_light_if.sv
// Button and LED bundle between the bicycle light controller and its surroundings.
// The master side drives the (already synchronised) buttons and observes the outputs;
// the slave side is the controller itself.
interface bike_light_if #(
    parameter int N_LIGHTS = 4,
    parameter int N_RATES  = 8
);
    localparam int RATE_W = $clog2(N_RATES);

    logic                next;
    logic                faster;
    logic                slower;
    logic [N_LIGHTS-1:0] lights;
    logic [2:0]          mode;
    logic [RATE_W-1:0]   rate;

    modport master (
        output next,
        output faster,
        output slower,
        input  lights,
        input  mode,
        input  rate
    );

    modport slave (
        input  next,
        input  faster,
        input  slower,
        output lights,
        output mode,
        output rate
    );
endinterface

// File: rtl/bike_light_ctrl.sv
// Multi-channel bicycle light controller: OFF/ON/BLINK/CHASE/DIM modes selected by a
// "next" button, with a saturating blink/chase rate and fixed-duty PWM dimming.
// All outputs are registered; button edges are detected against a one-cycle history.
module bike_light_ctrl #(
    parameter int N_LIGHTS     = 4,
    parameter int TICK_DIV     = 1_000_000,
    parameter int N_RATES      = 8,
    parameter int DEFAULT_RATE = 3,
    parameter int PWM_BITS     = 4,
    parameter int DIM_DUTY     = 4
) (
    input  logic         clk,
    input  logic         reset,
    bike_light_if.slave  bus
);
    localparam int RATE_W = $clog2(N_RATES);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0]   TICK_MAX   = TICK_W'(TICK_DIV - 1);
    localparam logic [RATE_W-1:0]   RATE_MAX   = RATE_W'(N_RATES - 1);
    localparam logic [RATE_W-1:0]   RATE_INIT  = RATE_W'(DEFAULT_RATE);
    localparam logic [PWM_BITS:0]   DIM_DUTY_V = (PWM_BITS + 1)'(DIM_DUTY);

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_CHASE = 3'd3,
        MODE_DIM   = 3'd4
    } mode_e;

    mode_e                mode_q;
    mode_e                mode_d;
    logic                 next_q;
    logic                 faster_q;
    logic                 slower_q;
    logic                 edge_next;
    logic                 edge_faster;
    logic                 edge_slower;
    logic                 mode_chg;
    logic [RATE_W-1:0]    rate_q;
    logic [TICK_W-1:0]    tick_cnt;
    logic                 tick;
    logic [RATE_W-1:0]    phase_q;
    logic                 step;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 dim_on;
    logic [N_LIGHTS-1:0]  pat_p0;
    logic [N_LIGHTS-1:0]  lights_p1;

    // Rotate left by one; with a single channel this returns the input unchanged.
    function automatic logic [N_LIGHTS-1:0] rotl(input logic [N_LIGHTS-1:0] v);
        return (v << 1) | (v >> (N_LIGHTS - 1));
    endfunction

    assign edge_next   = bus.next   & ~next_q;
    assign edge_faster = bus.faster & ~faster_q;
    assign edge_slower = bus.slower & ~slower_q;
    assign mode_chg    = edge_next;

    assign tick   = (tick_cnt == TICK_MAX);
    assign step   = tick && (phase_q >= rate_q);
    assign dim_on = ({1'b0, pwm_cnt} < DIM_DUTY_V);

    // Button history; held at 1 in reset so a button held through release gives no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_q   <= 1'b1;
            faster_q <= 1'b1;
            slower_q <= 1'b1;
        end else begin
            next_q   <= bus.next;
            faster_q <= bus.faster;
            slower_q <= bus.slower;
        end
    end

    // Mode state register.
    always_ff @(posedge clk) begin
        if (reset) mode_q <= MODE_OFF;
        else       mode_q <= mode_d;
    end

    // Mode sequencing: each next edge advances one step around the ring.
    always_comb begin
        mode_d = mode_q;
        if (edge_next) begin
            case (mode_q)
                MODE_OFF:   mode_d = MODE_ON;
                MODE_ON:    mode_d = MODE_BLINK;
                MODE_BLINK: mode_d = MODE_CHASE;
                MODE_CHASE: mode_d = MODE_DIM;
                MODE_DIM:   mode_d = MODE_OFF;
                default:    mode_d = MODE_OFF;
            endcase
        end
    end

    // Saturating rate index; opposing edges in one cycle cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q <= RATE_INIT;
        end else if (edge_faster && !edge_slower) begin
            if (rate_q != '0) rate_q <= rate_q - RATE_W'(1);
        end else if (edge_slower && !edge_faster) begin
            if (rate_q != RATE_MAX) rate_q <= rate_q + RATE_W'(1);
        end
    end

    // Base tick divider, restarted on every mode change.
    always_ff @(posedge clk) begin
        if (reset || mode_chg) tick_cnt <= '0;
        else if (tick)         tick_cnt <= '0;
        else                   tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // Phase counter over ticks; >= lets a lowered rate fire on the very next tick.
    always_ff @(posedge clk) begin
        if (reset || mode_chg) phase_q <= '0;
        else if (tick) begin
            if (phase_q >= rate_q) phase_q <= '0;
            else                   phase_q <= phase_q + RATE_W'(1);
        end
    end

    // Free-running PWM counter for DIM, aligned to zero on mode entry.
    always_ff @(posedge clk) begin
        if (reset || mode_chg) pwm_cnt <= '0;
        else                   pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // Stage p0: blink/chase pattern, loaded with the entry value of the new mode.
    always_ff @(posedge clk) begin
        if (mode_chg) begin
            case (mode_d)
                MODE_BLINK: pat_p0 <= '1;
                MODE_CHASE: pat_p0 <= N_LIGHTS'(1);
                default:    pat_p0 <= '0;
            endcase
        end else if (step) begin
            case (mode_q)
                MODE_BLINK: pat_p0 <= ~pat_p0;
                MODE_CHASE: pat_p0 <= rotl(pat_p0);
                default:    pat_p0 <= pat_p0;
            endcase
        end
    end

    // Stage p1: registered LED drive selected by the current mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            lights_p1 <= '0;
        end else begin
            case (mode_q)
                MODE_OFF:   lights_p1 <= '0;
                MODE_ON:    lights_p1 <= '1;
                MODE_BLINK: lights_p1 <= pat_p0;
                MODE_CHASE: lights_p1 <= pat_p0;
                MODE_DIM:   lights_p1 <= dim_on ? '1 : '0;
                default:    lights_p1 <= '0;
            endcase
        end
    end

    assign bus.lights = lights_p1;
    assign bus.mode   = mode_q;
    assign bus.rate   = rate_q;
endmodule

// File: tb/tb_bike_light_ctrl.sv
// Testbench for bike_light_ctrl: directed walk through every mode followed by random
// button traffic, compared each cycle with a behavioural model of the light rules.
module tb_bike_light_ctrl;
    localparam int N_LIGHTS = 4;
    localparam int TDIV     = 4;
    localparam int NR       = 4;
    localparam int DEF_RATE = 1;
    localparam int PWM_B    = 2;
    localparam int DUTY     = 1;
    localparam int PWM_LEN  = 1 << PWM_B;

    logic clk = 1'b0;
    logic reset;

    bike_light_if #(.N_LIGHTS(N_LIGHTS), .N_RATES(NR)) bus ();

    bike_light_ctrl #(
        .N_LIGHTS(N_LIGHTS), .TICK_DIV(TDIV), .N_RATES(NR),
        .DEFAULT_RATE(DEF_RATE), .PWM_BITS(PWM_B), .DIM_DUTY(DUTY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: mode index, rate, cycles since entry, ticks since last step, steps since entry.
    int m_mode, m_rate, m_cyc, m_ticks, m_steps, m_lights;
    bit pn, pf, ps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit en, ef, es;
        if (reset) begin
            m_mode = 0; m_rate = DEF_RATE; m_cyc = 0; m_ticks = 0; m_steps = 0;
            m_lights = 0; pn = 1; pf = 1; ps = 1;
        end else begin
            en = bus.next && !pn;
            ef = bus.faster && !pf;
            es = bus.slower && !ps;
            case (m_mode)
                0: m_lights = 0;
                1: m_lights = 'hF;
                2: m_lights = (m_steps % 2 == 0) ? 'hF : 0;
                3: m_lights = 1 << (m_steps % N_LIGHTS);
                default: m_lights = ((m_cyc % PWM_LEN) < DUTY) ? 'hF : 0;
            endcase
            if (m_cyc % TDIV == TDIV - 1) begin
                if (m_ticks >= m_rate) begin m_steps++; m_ticks = 0; end
                else m_ticks++;
            end
            if (en) begin
                m_mode = (m_mode + 1) % 5; m_cyc = 0; m_ticks = 0; m_steps = 0;
            end else begin
                m_cyc++;
            end
            if (ef && !es && m_rate > 0) m_rate--;
            else if (es && !ef && m_rate < NR - 1) m_rate++;
            pn = bus.next; pf = bus.faster; ps = bus.slower;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("model_mode", bus.mode, m_mode);
            check("model_rate", bus.rate, m_rate);
            check("model_lights", bus.lights, m_lights);
        end
    endtask

    task automatic hold(input logic n, input logic f, input logic s, input int cycles);
        bus.next = n; bus.faster = f; bus.slower = s;
        run(cycles);
    endtask

    task automatic tap_next();
        hold(1'b1, 1'b0, 1'b0, 1);
        hold(1'b0, 1'b0, 1'b0, 3);
    endtask

    initial begin : stim
        int exp_walk [4] = '{2, 3, 4, 0};
        logic [3:0] exp_l;

        // Reset with next held; release must not count as a press.
        reset = 1'b1;
        hold(1'b1, 1'b0, 1'b0, 2);
        check("rst_mode", bus.mode, 0);
        check("rst_lights", bus.lights, 0);
        check("rst_rate", bus.rate, 1);
        reset = 1'b0;
        hold(1'b1, 1'b0, 1'b0, 5);
        check("rel_mode", bus.mode, 0);
        check("rel_lights", bus.lights, 0);
        hold(1'b0, 1'b0, 1'b0, 3);

        // Mode walk; ON lights appear two edges after the press.
        bus.next = 1'b1;
        run(1);
        check("walk_on_mode", bus.mode, 1);
        check("walk_on_lag", bus.lights, 0);
        run(1);
        check("walk_on_lights", bus.lights, 'hF);
        hold(1'b1, 1'b0, 1'b0, 3);
        hold(1'b0, 1'b0, 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 1'b0, 1'b0, 5);
            hold(1'b0, 1'b0, 1'b0, 5);
            check("walk_mode", bus.mode, exp_walk[i]);
        end

        // BLINK at rate 1: 8 on, 8 off.
        tap_next();
        hold(1'b1, 1'b0, 1'b0, 1);
        bus.next = 1'b0;
        check("blink_mode", bus.mode, 2);
        for (int c = 1; c <= 16; c++) begin
            run(1);
            check("blink_pat", bus.lights, (c <= 8) ? 'hF : 0);
        end
        hold(1'b0, 1'b1, 1'b0, 2);
        hold(1'b0, 1'b0, 1'b0, 2);
        check("faster_rate", bus.rate, 0);
        hold(1'b0, 1'b1, 1'b0, 2);
        hold(1'b0, 1'b0, 1'b0, 2);
        check("faster_sat", bus.rate, 0);
        run(24);

        // CHASE at rate 1: one-hot rotate every 8 cycles.
        hold(1'b0, 1'b0, 1'b1, 2);
        hold(1'b0, 1'b0, 1'b0, 2);
        check("slower_rate", bus.rate, 1);
        hold(1'b1, 1'b0, 1'b0, 1);
        bus.next = 1'b0;
        check("chase_mode", bus.mode, 3);
        for (int c = 1; c <= 40; c++) begin
            run(1);
            exp_l = 4'b0001 << (((c - 1) / 8) % 4);
            check("chase_pat", bus.lights, exp_l);
        end
        for (int i = 0; i < 3; i++) begin
            hold(1'b0, 1'b0, 1'b1, 2);
            hold(1'b0, 1'b0, 1'b0, 2);
        end
        check("slower_sat", bus.rate, 3);
        run(40);

        // DIM: 1 cycle on, 3 off; simultaneous faster+slower is a no-op.
        hold(1'b1, 1'b0, 1'b0, 1);
        bus.next = 1'b0;
        check("dim_mode", bus.mode, 4);
        for (int c = 1; c <= 8; c++) begin
            run(1);
            check("dim_pat", bus.lights, ((c - 1) % 4 == 0) ? 'hF : 0);
        end
        hold(1'b0, 1'b1, 1'b1, 1);
        hold(1'b0, 1'b0, 1'b0, 2);
        check("both_rate", bus.rate, 3);

        // Reset in the middle of BLINK.
        tap_next();
        tap_next();
        tap_next();
        check("pre_rst_mode", bus.mode, 2);
        run(10);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("mid_rst_mode", bus.mode, 0);
        check("mid_rst_lights", bus.lights, 0);
        check("mid_rst_rate", bus.rate, 1);
        hold(1'b0, 1'b0, 1'b0, 2);
        hold(1'b1, 1'b0, 1'b0, 1);
        check("post_rst_on", bus.mode, 1);
        hold(1'b0, 1'b0, 1'b0, 3);

        // Random button traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.next   = ~bus.next;
            if ($urandom_range(0, 15) == 0) bus.faster = ~bus.faster;
            if ($urandom_range(0, 15) == 0) bus.slower = ~bus.slower;
            reset = ($urandom_range(0, 299) == 0);
            run(1);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bike_light_ctrl.md
Name: bike_light_ctrl

Overview:
- Parametrised rear/front bicycle light controller, successor to the single-output bicycle light FSM.
- Drives N_LIGHTS LED channels from three push-button inputs (next, faster, slower).
- Modes: OFF, ON, BLINK, CHASE and DIM, with a saturating adjustable blink/chase rate and PWM dimming.
- Sits between the debounced button synchronisers and the LED output pins.

Parameters:
- N_LIGHTS, 4: number of LED channels, must be >= 1.
- TICK_DIV, 1_000_000: clk cycles per base tick, must be >= 1.
- N_RATES, 8: number of selectable rate steps, must be >= 2.
- DEFAULT_RATE, 3: rate index after reset, must be < N_RATES.
- PWM_BITS, 4: width of the DIM-mode PWM counter.
- DIM_DUTY, 4: on-cycles per 2^PWM_BITS cycles in DIM mode, must be <= 2^PWM_BITS.

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- next, input, 1: level button (already synchronised); a rising edge advances the mode.
- faster, input, 1: level button; a rising edge decrements the rate index.
- slower, input, 1: level button; a rising edge increments the rate index.
- lights, output, N_LIGHTS: registered LED drive, 1 = on.
- mode, output, 3: current mode encoding (OFF=0, ON=1, BLINK=2, CHASE=3, DIM=4).
- rate, output, clog2(N_RATES): current rate index.

Behaviour:
- Reset (synchronous, active-high, checked every cycle, overrides everything, including mid-blink or mid-chase):
  - mode=OFF, lights=0, rate=DEFAULT_RATE.
  - Tick counter, phase counter and PWM counter cleared.
  - Button history registers set to 1, so a button held through reset release does not produce an edge.
- Edge detect: edge_x = x & ~x_q, with x_q <= x every cycle. A held button yields exactly one edge.
- Mode sequence on edge_next: OFF->ON->BLINK->CHASE->DIM->OFF (wraps).
  - mode updates on the clock edge where edge_next is true.
  - lights reflect the new mode one cycle later.
  - Total: lights change 2 clk edges after the first edge that samples next=1.
- Rate control:
  - edge_faster: rate-1, saturating at 0.
  - edge_slower: rate+1, saturating at N_RATES-1.
  - edge_faster and edge_slower in the same cycle: rate unchanged.
  - Rate is accepted in every mode, including OFF, and persists across mode changes.
- Base tick: tick counter counts 0..TICK_DIV-1 and pulses tick on the wrap. The counter is cleared on any mode change.
- Phase counter: counts ticks 0..rate and emits step when phase==rate && tick, then clears.
  - Step period = (rate+1)*TICK_DIV cycles.
  - Cleared on any mode change.
  - If rate drops below the current phase value, the next tick emits step.
- Per-mode lights, registered:
  - OFF: all 0.
  - ON: all 1.
  - BLINK: entry = all 1; each step inverts all bits.
  - CHASE: entry = one-hot bit0; each step rotates left (bit N_LIGHTS-1 wraps to bit0). With N_LIGHTS=1 this is a constant 1.
  - DIM: PWM counter free-runs 0..2^PWM_BITS-1, starting at 0 on entry.
    - lights = all 1 when pwm_cnt < DIM_DUTY, else all 0.
    - DIM_DUTY=0 means always off; DIM_DUTY=2^PWM_BITS means always on.
- Simultaneous next with faster/slower: both take effect in the same cycle; the new mode uses the new rate.
- No combinational path from inputs to outputs.

Test Plan:
(Bench parameters: TICK_DIV=4, N_RATES=4, DEFAULT_RATE=1, N_LIGHTS=4, PWM_BITS=2, DIM_DUTY=1.)
1. Reset: hold reset 2 cycles with next=1, then release holding next=1 for 5 cycles -> mode=0, lights=4'b0000, rate=1; no mode change.
2. Mode walk: starting from OFF, press next (5 cycles high, 5 low) ×5 -> mode 1,2,3,4,0. In ON, lights=4'b1111, 2 cycles after the press.
3. BLINK at rate 1: lights=1111 for 8 cycles, 0000 for 8 cycles, repeating (period 16). Press faster -> rate=0, period 8. Press faster again -> rate stays 0.
4. CHASE at rate 1: lights sequence 0001,0010,0100,1000,0001, 8 cycles each. Press slower ×3 -> rate=3 (saturates), step every 16 cycles.
5. DIM: lights=1111 for 1 cycle, then 0000 for 3 cycles, repeating. Pulse faster and slower together -> rate unchanged.
6. Mid-BLINK reset asserted for 1 cycle -> next cycle mode=0, lights=0000, rate=1; the following next press enters ON.
